// File: rtl/int_ctrl.sv
// int_ctrl: eight-source interrupt controller (six edge-detected hardware lines, two software
// set lines) with mask, global enable and single-level service. Build option: IRQ_SYNC_EN.
//
//   state      | meaning
//   -----------+-------------------------------------------------------------
//   ST_IDLE    | waiting for an enabled pending source at an instruction boundary
//   ST_REQ     | one cycle; exl_set asserted towards the exception register block
//   ST_SERVICE | handler running; leaves on eret, no nested takes
module int_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  irq_in,
   input  logic [1:0]  sw_set,
   input  logic        im_wr,
   input  logic [7:0]  im_wdata,
   input  logic        ie,
   input  logic        instr_commit,
   input  logic [31:0] resume_pc,
   input  logic        eret,
   output logic        exl_set,
   output logic [31:0] exc_pc,
   output logic        exl_clear,
   output logic [2:0]  cause_code,
   output logic [7:0]  pending,
   output logic        in_service
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_SERVICE = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [5:0]  w_irq_src;
   logic [5:0]  r_irq_hist;
   logic [5:0]  w_irq_rise;
   logic [7:0]  w_events;
   logic [7:0]  r_pending;
   logic [7:0]  r_mask;
   logic [7:0]  w_active;
   logic [2:0]  w_win_idx;
   logic [7:0]  w_take_clr;
   logic        w_take;
   logic [31:0] r_exc_pc;
   logic [2:0]  r_cause;
   logic        r_exl_clear;

`ifdef IRQ_SYNC_EN
   logic [5:0] r_sync1;
   logic [5:0] r_sync2;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= irq_in;
         r_sync2 <= r_sync1;
      end
   end

   assign w_irq_src = r_sync2;
`else
   assign w_irq_src = irq_in;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_irq_hist <= '0;
      end else begin
         r_irq_hist <= w_irq_src;
      end
   end

   assign w_irq_rise = w_irq_src & ~r_irq_hist;
   assign w_events   = {w_irq_rise, sw_set};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_mask <= 8'hFF;
      end else if (im_wr) begin
         r_mask <= im_wdata;
      end
   end

   assign w_active = r_pending & r_mask;

   // Ascending scan: the last set bit seen is the highest index, which has priority.
   always_comb begin
      w_win_idx = 3'd0;
      for (int k = 0; k < 8; k++) begin
         if (w_active[k]) begin
            w_win_idx = 3'(k);
         end
      end
   end

   assign w_take_clr = w_take ? (8'b0000_0001 << w_win_idx) : 8'h00;

   // A new event on the bit being taken wins over the clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pending <= '0;
      end else begin
         r_pending <= (r_pending & ~w_take_clr) | w_events;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_take      = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (ie && instr_commit && (w_active != 8'h00)) begin
               w_take      = 1'b1;
               w_state_nxt = ST_REQ;
            end
         end
         ST_REQ: begin
            w_state_nxt = ST_SERVICE;
         end
         ST_SERVICE: begin
            if (eret) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_exc_pc <= '0;
         r_cause  <= '0;
      end else if (w_take) begin
         r_exc_pc <= resume_pc;
         r_cause  <= w_win_idx;
      end
   end

   // eret outside SERVICE is dropped, so the clear pulse only follows a real return.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_exl_clear <= 1'b0;
      end else begin
         r_exl_clear <= (r_state == ST_SERVICE) && eret;
      end
   end

   assign exl_set    = (r_state == ST_REQ);
   assign in_service = (r_state == ST_SERVICE);
   assign exl_clear  = r_exl_clear;
   assign exc_pc     = r_exc_pc;
   assign cause_code = r_cause;
   assign pending    = r_pending;

endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed scenarios plus randomized traffic for int_ctrl, every cycle compared
// against a rule-level reference model of the pending set and the take/return sequence.
module tb_int_ctrl;

`ifdef IRQ_SYNC_EN
   localparam int SYNC_DLY = 2;
`else
   localparam int SYNC_DLY = 0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [5:0]  irq_in = '0;
   logic [1:0]  sw_set = '0;
   logic        im_wr = 1'b0;
   logic [7:0]  im_wdata = '0;
   logic        ie = 1'b0;
   logic        instr_commit = 1'b0;
   logic [31:0] resume_pc = '0;
   logic        eret = 1'b0;
   logic        exl_set;
   logic [31:0] exc_pc;
   logic        exl_clear;
   logic [2:0]  cause_code;
   logic [7:0]  pending;
   logic        in_service;

   int n_chk = 0;
   int n_err = 0;

   // reference model: busy = 0 waiting, 1 request cycle, 2 handler running
   int          m_busy;
   bit [7:0]    m_pend;
   bit [7:0]    m_mask;
   bit [5:0]    m_prev;
   bit [5:0]    m_line [0:2];
   bit [31:0]   m_pc;
   int          m_cause;
   bit          m_clr;

   int_ctrl dut (
      .clk(clk), .rst(rst), .irq_in(irq_in), .sw_set(sw_set), .im_wr(im_wr),
      .im_wdata(im_wdata), .ie(ie), .instr_commit(instr_commit), .resume_pc(resume_pc),
      .eret(eret), .exl_set(exl_set), .exc_pc(exc_pc), .exl_clear(exl_clear),
      .cause_code(cause_code), .pending(pending), .in_service(in_service)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_busy = 0; m_pend = '0; m_mask = 8'hFF; m_prev = '0;
      for (int i = 0; i < 3; i++) m_line[i] = '0;
      m_pc = '0; m_cause = 0; m_clr = 0;
   endtask

   task automatic compare_all();
      chk("exl_set",    exl_set,    (m_busy == 1));
      chk("in_service", in_service, (m_busy == 2));
      chk("exl_clear",  exl_clear,  m_clr);
      chk("pending",    pending,    m_pend);
      chk("cause_code", cause_code, m_cause);
      chk("exc_pc",     exc_pc,     m_pc);
   endtask

   // Apply one clock of the current inputs to the model, then to the DUT, then compare.
   task automatic step();
      bit [5:0] seen;
      bit [7:0] evt;
      bit [7:0] cand;
      int       top;
      bit       take;
      seen = (SYNC_DLY == 2) ? m_line[1] : irq_in;
      evt  = {seen & ~m_prev, sw_set};
      cand = m_pend & m_mask;
      top  = -1;
      for (int k = 7; k >= 0; k--) if (cand[k] && top < 0) top = k;
      take = (m_busy == 0) && ie && instr_commit && (top >= 0);
      m_clr = (m_busy == 2) && eret;
      if (take) begin
         m_pend[top] = 1'b0;
         m_cause = top;
         m_pc = resume_pc;
      end
      m_pend = m_pend | evt;
      if (im_wr) m_mask = im_wdata;
      m_busy = take ? 1 : (m_busy == 1) ? 2 : (m_busy == 2 && eret) ? 0 : m_busy;
      m_prev = seen;
      m_line[1] = m_line[0];
      m_line[0] = irq_in;
      @(posedge clk);
      @(negedge clk);
      compare_all();
   endtask

   task automatic return_from_handler();
      eret = 1'b1; step();
      eret = 1'b0; step();
   endtask

   initial begin
      int lat;
      m_reset();
      #3;
      chk("rst_pending",  pending, 8'h00);
      chk("rst_exl_set",  exl_set, 1'b0);
      chk("rst_in_serv",  in_service, 1'b0);
      chk("rst_exc_pc",   exc_pc, 32'h0);
      chk("rst_cause",    cause_code, 3'd0);
      chk("rst_exl_clr",  exl_clear, 1'b0);
      @(negedge clk); #1 rst = 1'b1;

      // basic take
      ie = 1'b1; instr_commit = 1'b1; resume_pc = 32'h0000_1004;
      irq_in[3] = 1'b1; step();
      irq_in = '0;
      repeat (SYNC_DLY) step();
      chk("basic_pend5", pending[5], 1'b1);
      step();
      chk("basic_exl_set", exl_set, 1'b1);
      chk("basic_cause",   cause_code, 3'd5);
      chk("basic_pc",      exc_pc, 32'h0000_1004);
      chk("basic_cleared", pending[5], 1'b0);
      step();
      chk("basic_one_pulse", exl_set, 1'b0);
      chk("basic_in_serv",   in_service, 1'b1);
      eret = 1'b1; step();
      chk("basic_exl_clr", exl_clear, 1'b1);
      eret = 1'b0; step();
      chk("basic_clr_one", exl_clear, 1'b0);

      // priority between hardware line 0 and software line 0
      instr_commit = 1'b0;
      sw_set = 2'b01; irq_in[0] = 1'b1; step();
      sw_set = '0; irq_in = '0;
      repeat (SYNC_DLY) step();
      chk("prio_both_pend", pending, 8'h05);
      instr_commit = 1'b1; step();
      chk("prio_cause2", cause_code, 3'd2);
      chk("prio_left",   pending, 8'h01);
      instr_commit = 1'b0; step();
      eret = 1'b1; step();
      eret = 1'b0; instr_commit = 1'b1; step();
      chk("prio_cause0", cause_code, 3'd0);
      step();
      return_from_handler();

      // mask and global enable
      im_wr = 1'b1; im_wdata = 8'h00; step();
      im_wr = 1'b0; irq_in[5] = 1'b1; step();
      irq_in = '0;
      repeat (SYNC_DLY + 3) step();
      chk("mask_pend7", pending[7], 1'b1);
      chk("mask_no_take", in_service, 1'b0);
      im_wr = 1'b1; im_wdata = 8'h80; step();
      im_wr = 1'b0; step();
      chk("mask_take7", cause_code, 3'd7);
      chk("mask_exl", exl_set, 1'b1);
      step();
      return_from_handler();
      im_wr = 1'b1; im_wdata = 8'hFF; ie = 1'b0; step();
      im_wr = 1'b0; irq_in[4] = 1'b1; step();
      irq_in = '0;
      repeat (SYNC_DLY + 3) step();
      chk("ie0_pend6", pending[6], 1'b1);
      chk("ie0_no_take", in_service, 1'b0);
      ie = 1'b1; step();
      chk("ie1_take6", cause_code, 3'd6);
      step();
      return_from_handler();

      // no nesting, eret handling
      sw_set = 2'b10; step();
      sw_set = '0; step();
      chk("nest_cause1", cause_code, 3'd1);
      step();
      irq_in[1] = 1'b1; step();
      irq_in = '0;
      repeat (SYNC_DLY + 1) step();
      chk("nest_pend3", pending[3], 1'b1);
      chk("nest_still_serv", in_service, 1'b1);
      eret = 1'b1; step();
      chk("nest_clr", exl_clear, 1'b1);
      eret = 1'b0; step();
      chk("nest_take3", cause_code, 3'd3);
      chk("nest_clr_one", exl_clear, 1'b0);
      step();
      return_from_handler();
      eret = 1'b1; step();
      chk("idle_eret_noclr", exl_clear, 1'b0);
      eret = 1'b0; step();

      // asynchronous reset in the middle of a handler
      resume_pc = 32'hDEAD_BEE0;
      sw_set = 2'b11; step();
      sw_set = '0; step(); step();
      chk("mid_in_serv", in_service, 1'b1);
      @(posedge clk); #2 rst = 1'b0; #1;
      m_reset();
      chk("arst_in_serv", in_service, 1'b0);
      chk("arst_exc_pc",  exc_pc, 32'h0);
      chk("arst_pending", pending, 8'h00);
      chk("arst_exl_clr", exl_clear, 1'b0);
      @(negedge clk);
      compare_all();
      #2 rst = 1'b1;
      eret = 1'b1; step(); step();
      chk("arst_no_clr", exl_clear, 1'b0);
      eret = 1'b0;

      // synchronizer latency: first cycle the pending bit is visible, bounded
      instr_commit = 1'b0;
      irq_in[2] = 1'b1;
      lat = 0;
      for (int c = 1; c <= 8 && lat == 0; c++) begin
         step();
         irq_in = '0;
         if (pending[4]) lat = c;
      end
      chk("sync_latency", lat, 1 + SYNC_DLY);
      instr_commit = 1'b1; step(); step();
      return_from_handler();

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         irq_in       = 6'($urandom);
         sw_set       = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
         im_wr        = ($urandom_range(0, 15) == 0);
         im_wdata     = 8'($urandom);
         ie           = ($urandom_range(0, 5) != 0);
         instr_commit = $urandom_range(0, 1) == 1;
         eret         = ($urandom_range(0, 3) == 0);
         resume_pc    = $urandom;
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 The block SHALL have one clock and one reset; reset SHALL be asynchronous and active-low.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst  input  1  asynchronous active-low reset; 0 = reset asserted.
REQ-004 irq_in  input  6  hardware interrupt lines; a rising edge creates an event; lines map to pending[7:2].
REQ-005 sw_set  input  2  software interrupt set pulses; lines map to pending[1:0].
REQ-006 im_wr  input  1  mask write strobe.
REQ-007 im_wdata  input  8  new interrupt mask value; 1 = source enabled.
REQ-008 ie  input  1  global interrupt enable.
REQ-009 instr_commit  input  1  pipeline is at an instruction boundary this cycle.
REQ-010 resume_pc  input  32  address to resume at if an interrupt is taken this cycle.
REQ-011 eret  input  1  exception-return pulse from the decoder.
REQ-012 exl_set  output  1  one-cycle request to the exception register block; connects to its EXLSet input.
REQ-013 exc_pc  output  32  return address captured for the exception register block; connects to its PC input.
REQ-014 exl_clear  output  1  one-cycle exception-level clear; connects to its EXLClear input.
REQ-015 cause_code  output  3  index (0-7) of the serviced source.
REQ-016 pending  output  8  raw pending bits, unmasked.
REQ-017 in_service  output  1  1 while in state SERVICE.

Function
REQ-018 Event detection SHALL use a registered copy of irq_in; pending[k+2] SHALL be set in the cycle after irq_in[k] goes from 0 to 1.
REQ-019 sw_set[j]=1 SHALL set pending[j] on the next edge.
REQ-020 The mask register SHALL load im_wdata on an edge where im_wr=1, and the new value SHALL take effect from the following cycle.
REQ-021 The FSM SHALL have three states: IDLE, REQ and SERVICE.
REQ-022 IDLE->REQ SHALL occur when ie=1, instr_commit=1 and (pending & mask) is nonzero.
REQ-023 On the IDLE->REQ edge, the block SHALL latch the highest-index set bit of (pending & mask) into cause_code.
REQ-024 On the IDLE->REQ edge, the block SHALL latch resume_pc into exc_pc.
REQ-025 On the IDLE->REQ edge, the block SHALL clear the winning pending bit.
REQ-026 exl_set SHALL be 1 only during REQ, so each taken interrupt produces exactly one pulse of one cycle.
REQ-027 REQ->SERVICE SHALL occur unconditionally on the next edge.
REQ-028 SERVICE->IDLE SHALL occur on an edge where eret=1.
REQ-029 exl_clear SHALL be 1 for exactly the one cycle after the eret edge.
REQ-030 eret asserted in IDLE or REQ SHALL be ignored and SHALL produce no exl_clear.
REQ-031 While in REQ or SERVICE, new events SHALL still set pending bits, but no further interrupt SHALL be taken (no nesting).
REQ-032 If a set event and a take-clear hit the same pending bit in the same cycle, the set SHALL win and the bit SHALL remain 1.
REQ-033 The earliest a new interrupt SHALL be taken is the cycle in which exl_clear is high, provided the take conditions of REQ-022 are met then.
REQ-034 exc_pc and cause_code SHALL hold their values until the next take.

Reset
REQ-035 While rst=0, the block SHALL immediately and asynchronously force state=IDLE, pending=0, mask=8'hFF, the irq_in history register=0, exc_pc=32'h0, cause_code=0, exl_set=0, exl_clear=0 and in_service=0.
REQ-036 A reset that occurs during REQ or SERVICE SHALL abandon the service with no exl_clear pulse.
REQ-037 Normal operation SHALL resume from the first rising clk edge after rst returns to 1.

Configuration
REQ-038 With macro IRQ_SYNC_EN defined, irq_in SHALL pass through a two-flop synchronizer before edge detection, adding exactly 2 cycles to the REQ-018 latency; the synchronizer flops SHALL reset to 0.
REQ-039 With IRQ_SYNC_EN undefined, irq_in SHALL be sampled directly and the synchronizer flops SHALL be absent.

Verification
REQ-040 Basic take: after reset, drive ie=1 and instr_commit=1 continuously with resume_pc=32'h0000_1004, and pulse irq_in[3]. Required: pending[5]=1, then exl_set pulses one cycle, cause_code=5, exc_pc=32'h0000_1004, in_service=1, pending[5]=0.
REQ-041 Priority: set sw_set=2'b01 and raise irq_in[0] in the same cycle, then take. Required: cause_code=2 and pending=8'h01 after the take; after eret, a second take gives cause_code=0.
REQ-042 Mask and ie: write im_wdata=8'h00, then pulse irq_in[5]. Required: no exl_set. Then write 8'h80. Required: a take with cause_code=7. With ie=0, events pend but no take occurs.
REQ-043 No nesting and eret: in SERVICE, pulse irq_in[1]. Required: pending[3]=1 and no exl_set. Then assert eret. Required: exl_clear pulses one cycle, the FSM returns to IDLE, and a take with cause_code=3 follows. eret while in IDLE produces no exl_clear.
REQ-044 Reset mid-service: assert rst=0 asynchronously, between clock edges, while in SERVICE. Required: in_service=0, exc_pc=0 and pending=0 immediately, with no exl_clear pulse.
REQ-045 Synchronizer latency: with IRQ_SYNC_EN defined, the pending bit SHALL set 2 cycles later than without the macro.
